// File: rtl/div_pkg.sv
// Shared definitions for the sequential RV32M divider: op encodings, FSM states
// and the iteration-count helper.
package div_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  function automatic int unsigned div_iters(int unsigned xlen, int unsigned bpc);
    return xlen / bpc;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the partial remainder left,
// try the subtraction, and append the resulting quotient bit to the shift register.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic [XLEN-1:0] shift_in,
  output logic [XLEN:0]   rem_out,
  output logic [XLEN-1:0] shift_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          q_bit;
  logic          msb_unused;

  // The partial remainder is always below the divisor, so its MSB is zero on entry.
  assign msb_unused = rem_in[XLEN];

  always_comb begin
    shifted   = {rem_in[XLEN-1:0], shift_in[XLEN-1]};
    diff      = shifted - {1'b0, divisor};
    q_bit     = ~diff[XLEN];
    rem_out   = q_bit ? diff : shifted;
    shift_out = {shift_in[XLEN-2:0], q_bit};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with start/ready/valid
// handshake, kill flush and single-cycle divide-by-zero / overflow results.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam int unsigned ITERS = div_iters(XLEN, BITS_PER_CYCLE);
  localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITERS - 1);

  div_state_t       state;
  logic [1:0]       op_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic [XLEN:0]    rem_q;
  logic [XLEN-1:0]  shift_q;
  logic [XLEN-1:0]  dvsr_q;
  logic [CNT_W-1:0] cnt;

  logic            is_signed;
  logic            is_rem;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] fix_res;
  logic [XLEN:0]   rem_next;
  logic [XLEN-1:0] shift_next;

  always_comb begin
    is_signed = ~op[0];
    is_rem    = op[1];
    a_neg     = is_signed & dividend[XLEN-1];
    b_neg     = is_signed & divisor[XLEN-1];
    // The most negative value maps onto itself, which reads correctly as unsigned.
    a_abs     = a_neg ? -dividend : dividend;
    b_abs     = b_neg ? -divisor : divisor;
    div_zero  = (divisor == '0);
    overflow  = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
    if (div_zero) begin
      special_res = is_rem ? dividend : '1;
    end else begin
      special_res = is_rem ? '0 : dividend;
    end
  end

  always_comb begin
    fix_res = shift_q;
    if (op_q == DIV_OP_DIV) begin
      fix_res = q_neg_q ? -shift_q : shift_q;
    end else if (op_q == DIV_OP_REM) begin
      fix_res = r_neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    end else if (op_q == DIV_OP_REMU) begin
      fix_res = rem_q[XLEN-1:0];
    end
  end

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : step
    logic [XLEN:0]   r_in;
    logic [XLEN:0]   r_out;
    logic [XLEN-1:0] s_in;
    logic [XLEN-1:0] s_out;

    if (g == 0) begin : first
      assign r_in = rem_q;
      assign s_in = shift_q;
    end else begin : chained
      assign r_in = step[g-1].r_out;
      assign s_in = step[g-1].s_out;
    end

    div_step #(
      .XLEN(XLEN)
    ) u_step (
      .rem_in   (r_in),
      .divisor  (dvsr_q),
      .shift_in (s_in),
      .rem_out  (r_out),
      .shift_out(s_out)
    );
  end

  assign rem_next   = step[BITS_PER_CYCLE-1].r_out;
  assign shift_next = step[BITS_PER_CYCLE-1].s_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b1;
      valid   <= 1'b0;
      result  <= '0;
      op_q    <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      rem_q   <= '0;
      shift_q <= '0;
      dvsr_q  <= '0;
      cnt     <= '0;
    end else begin
      valid <= 1'b0;
      if (kill) begin
        state <= IDLE;
        ready <= 1'b1;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              op_q    <= op;
              q_neg_q <= a_neg ^ b_neg;
              r_neg_q <= a_neg;
              if (div_zero || overflow) begin
                result <= special_res;
                valid  <= 1'b1;
                ready  <= 1'b1;
                state  <= DONE;
              end else begin
                rem_q   <= '0;
                shift_q <= a_abs;
                dvsr_q  <= b_abs;
                cnt     <= CNT_INIT;
                ready   <= 1'b0;
                state   <= CALC;
              end
            end else begin
              state <= IDLE;
            end
          end
          CALC: begin
            rem_q   <= rem_next;
            shift_q <= shift_next;
            cnt     <= cnt - 1'b1;
            if (cnt == '0) begin
              state <= FIX;
            end
          end
          FIX: begin
            result <= fix_res;
            valid  <= 1'b1;
            ready  <= 1'b1;
            state  <= DONE;
          end
          default: begin
            state <= IDLE;
            ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
